// File: rtl/memory_responder.sv
// memory_responder: word-addressed memory that serves the controller port and a valid/ready preload port.
// Latency: reads and writes complete at the next rising edge; read data and address error are registered.
// Backpressure: o_load_ready drops while the controller makes a request or a clear runs; preload then waits.
// Build option: define MEM_CLEAR_ON_RESET_EN to zero the whole array after every reset (o_busy high meanwhile).

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module memory_responder #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] memory_address,
  input  logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic                  memory_write_enable,
  input  logic                  memory_read_enable,
  output logic [DATA_WIDTH-1:0] memory_read_data,
  input  logic                  i_load_valid,
  input  logic [ADDR_BITS-1:0]  i_load_address,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic                  o_load_ready,
  output logic                  o_busy,
  output logic                  o_address_error
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic [ADDR_BITS-1:0]  word_addr;
  logic                  ctrl_req;
  logic                  ctrl_wr;
  logic                  load_fire;
  logic                  serve;
  logic                  clr_wr;
  logic [ADDR_BITS-1:0]  clr_addr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  err_q;

  // Only the low ADDR_BITS of the controller address are implemented; any upper bit set is an error.
  assign in_range  = ~|memory_address[DATA_WIDTH-1:ADDR_BITS];
  assign word_addr = memory_address[ADDR_BITS-1:0];
  assign ctrl_req  = memory_write_enable | memory_read_enable;

  // Controller always wins; the preload port only gets idle SERVE cycles.
  assign o_load_ready = rst_n & serve & ~ctrl_req;
  assign load_fire    = i_load_valid & o_load_ready;
  assign ctrl_wr      = rst_n & serve & memory_write_enable & in_range;

`ifdef MEM_CLEAR_ON_RESET_EN
  typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

  state_t               state_q;
  logic [ADDR_BITS-1:0] clr_cnt_q;
  logic                 busy_q;

  // Clear sequencer: one word per cycle from 0 up, then hand over to SERVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // Counter wraps back to 0 on the last word, ready for the next reset.
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_q <= ST_SERVE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_SERVE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign serve    = (state_q == ST_SERVE);
  assign clr_wr   = rst_n & (state_q == ST_CLEAR);
  assign clr_addr = clr_cnt_q;
  assign o_busy   = busy_q;
`else
  assign serve    = 1'b1;
  assign clr_wr   = 1'b0;
  assign clr_addr = '0;
  assign o_busy   = 1'b0;
`endif

  // Array write port: clear, then controller, then preload (the last two never coincide).
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_addr] <= '0;
    end else if (ctrl_wr) begin
      mem[word_addr] <= memory_write_data;
    end else if (load_fire) begin
      mem[i_load_address] <= i_load_data;
    end
  end

  // Registered read data (read-first against a same-cycle write) and one-cycle address error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      err_q <= 1'b0;
    end else if (!serve) begin
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= ctrl_req & ~in_range;
      if (memory_read_enable) begin
        rd_q <= in_range ? mem[word_addr] : '0;
      end
    end
  end

  assign memory_read_data = rd_q;
  assign o_address_error  = err_q;

endmodule

// File: doc/memory_responder.md
# memory_responder

Word-addressed data/program memory that serves as the responder end of the controller's memory port. It accepts one read and/or write request per cycle on `memory_address`/`memory_write_data`/`memory_write_enable`/`memory_read_enable` and returns registered read data on `memory_read_data`. A secondary preload port with a valid/ready handshake fills program images before or between controller accesses. An optional post-reset clear sequencer zeroes the whole array.

## Interface
- `DATA_WIDTH`, `` `DATA_WIDTH `` from define.v: word width; also the width of the address bus.
- `ADDR_BITS`, 8: implemented address bits; depth = 2^ADDR_BITS words.

- `clk`  in  1: clock; everything is on the rising edge.
- `rst_n`  in  1: reset; synchronous and active-low.
- `memory_address`  in  DATA_WIDTH: controller word address.
- `memory_write_data`  in  DATA_WIDTH: controller write data.
- `memory_write_enable`  in  1: controller write request.
- `memory_read_enable`  in  1: controller read request.
- `memory_read_data`  out  DATA_WIDTH: registered read data.
- `i_load_valid`  in  1: preload request valid.
- `i_load_address`  in  ADDR_BITS: preload word address.
- `i_load_data`  in  DATA_WIDTH: preload word.
- `o_load_ready`  out  1: preload can be accepted this cycle.
- `o_busy`  out  1: clear sequence in progress.
- `o_address_error`  out  1: one-cycle pulse for an out-of-range controller access.

## Operation
- States: CLEAR and SERVE. Reset enters CLEAR if the clear feature is compiled in, otherwise SERVE.
- **CLEAR**
  - A clear counter starts at 0 and writes zero to one word per cycle.
  - After word 2^ADDR_BITS−1 is written, the block moves to SERVE on the next cycle.
  - Controller requests and preloads are ignored.
  - `o_busy`=1, `o_load_ready`=0, `memory_read_data` is held at 0.
- **SERVE, priority**
  - A controller access (read or write enable high) wins over preload.
  - `o_load_ready` = SERVE && !memory_write_enable && !memory_read_enable. It is combinational from the enables.
  - A preload is accepted when `i_load_valid && o_load_ready`: `i_load_data` is written at `i_load_address`.
- **SERVE, range check**
  - An address is in range when bits [DATA_WIDTH-1:ADDR_BITS] of `memory_address` are all zero.
  - Out-of-range write: the array is unchanged.
  - Out-of-range read: returns 0.
  - Either case pulses `o_address_error` the next cycle.
- **Reads**
  - A read with `memory_read_enable`=1 loads `memory_read_data` with the array word at the next edge.
  - When `memory_read_enable`=0, `memory_read_data` holds its last value.
- **Read and write in the same cycle, same address:** read-first. `memory_read_data` returns the old word and the write lands.
- **Reset mid-operation**
  - Any cycle with `rst_n`=0 returns the FSM to its reset state, zeroes the counter and all outputs, and discards the request in that cycle.
  - Array contents persist unless CLEAR runs.

## Timing
- Read latency is 1 cycle: a request at edge N gives data valid after edge N+1, and it stays stable until the next read.
- Write latency is 1 cycle. A read of the same address issued in the following cycle returns the new data.
- Preload throughput is 1 word/cycle while the controller is idle.
- CLEAR lasts exactly 2^ADDR_BITS cycles after reset deassertion. `o_busy` falls on the cycle SERVE is entered.
- Reset values: `memory_read_data`=0, `o_address_error`=0, `o_load_ready`=0 during reset, `o_busy`=1 with clear compiled in, else 0.
- `o_address_error` is registered and is high for exactly one cycle per offending request.

## Configuration
- `MEM_CLEAR_ON_RESET_EN`
  - Defined: the CLEAR state and counter exist. After reset the array is all zeros and `o_busy` is high for 2^ADDR_BITS cycles.
  - Undefined: no counter and no CLEAR state. The block resets directly into SERVE, `o_busy` is tied to 0, and array contents after power-up are undefined (X in simulation).

## Test plan
- Reset with clear enabled, ADDR_BITS=4:
  - `o_busy`=1 for 16 cycles, then 0.
  - Reading addresses 0..15 returns 0.
  - `o_load_ready`=0 throughout CLEAR.
- Write 0x00A5 to address 3, then read 3 on the next cycle: `memory_read_data`=0x00A5 one cycle after the read request. The value holds while `memory_read_enable`=0.
- Address 5 holds 0x1111. Write 0x2222 and read address 5 in the same cycle: read data = 0x1111. A follow-up read returns 0x2222.
- Out-of-range access, address 0x0100 with ADDR_BITS=8:
  - Writing 0xBEEF leaves address 0x00 unchanged.
  - Reading returns 0.
  - `o_address_error` pulses for exactly one cycle, once per request.
- Preload contention:
  - Preload 0x1234 to address 7 while `memory_read_enable`=1: `o_load_ready`=0 and nothing is written.
  - Drop the enable: the preload is accepted, and reading 7 returns 0x1234.
- Assert `rst_n`=0 for one cycle midway through CLEAR (clear enabled): the counter restarts at 0 and `o_busy` stays high for a further full 2^ADDR_BITS cycles.
